// File: rtl/pbl_referee.sv
// pbl_referee: scores push-button latch rounds, shows the winner, clears the latch and ends the game at WIN_SCORE
//   clk, rst               clock, asynchronous active-high reset
//   push, tie, right       latch result (push held until clear)
//   clear                  one-cycle registered clear pulse to the latch
//   score_l, score_r       player scores
//   led_l, led_r, led_tie  round / game result indicators
//   game_over              set once a player reaches WIN_SCORE, held until rst
module pbl_referee #(
  parameter int HOLD_CYCLES = 8,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               tie,
  input  logic               right,
  output logic               clear,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               led_l,
  output logic               led_r,
  output logic               led_tie,
  output logic               game_over
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  typedef enum logic [2:0] {ARMED, HOLD, CLEAR, DRAIN, OVER} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic won;
  assign won = (score_l == WIN) || (score_r == WIN);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARMED;
      cnt       <= '0;
      clear     <= 1'b0;
      score_l   <= '0;
      score_r   <= '0;
      led_l     <= 1'b0;
      led_r     <= 1'b0;
      led_tie   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      case (state)
        ARMED: if (push) begin
          led_tie <= tie;
          led_r   <= !tie && right;
          led_l   <= !tie && !right;
          score_r <= (!tie && right) ? score_r + 1'b1 : score_r;
          score_l <= (!tie && !right) ? score_l + 1'b1 : score_l;
          cnt     <= CW'(HOLD_CYCLES - 1);
          state   <= HOLD;
        end
        // clear is raised on the same edge the FSM enters CLEAR so it is visible for exactly that cycle
        HOLD: if (cnt == '0) begin
          clear <= 1'b1;
          state <= CLEAR;
        end else begin
          cnt <= cnt - 1'b1;
        end
        CLEAR: begin
          clear   <= 1'b0;
          led_l   <= 1'b0;
          led_r   <= 1'b0;
          led_tie <= 1'b0;
          state   <= DRAIN;
        end
        // a latch that has not released yet gets another clear pulse
        DRAIN: if (push) begin
          clear <= 1'b1;
          state <= CLEAR;
        end else if (won) begin
          game_over <= 1'b1;
          led_l     <= score_l == WIN;
          led_r     <= score_l != WIN;
          state     <= OVER;
        end else begin
          state <= ARMED;
        end
        OVER: state <= OVER;
        default: state <= ARMED;
      endcase
    end
  end
endmodule
